wishbone_spi_slave: RTL

WISHBONE_SPI_SLAVE -- requirements
Module: wishbone_spi_slave

---
 rtl/wishbone_spi_slave_if.sv | 23 ++
 rtl/wishbone_spi_slave.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wishbone_spi_slave_if.sv
// Wishbone classic bus bundle between a bus master and the SPI slave register block.
// Signal suffixes are from the slave's point of view.
interface wishbone_spi_slave_if;
    logic [4:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wishbone_spi_slave.sv
// Wishbone register front-end for an SPI master core: TX/RX data, CTRL, DIVIDER and SS registers,
// single-cycle registered ack/err termination and a transfer-complete interrupt.
module wishbone_spi_slave (
    input  logic                 clk_in,
    input  logic                 rst_in,
    wishbone_spi_slave_if.slave  wb,
    input  logic [127:0]         rx_data_i,
    input  logic                 xfer_done_i,
    output logic [127:0]         tx_data_o,
    output logic [13:0]          ctrl_o,
    output logic [15:0]          divider_o,
    output logic [7:0]           ss_o,
    output logic                 int_o
);
    localparam logic [13:0] CTRL_WMASK = 14'h3F7F;
    localparam int          GO_BIT     = 8;
    localparam int          IE_BIT     = 12;

    logic [127:0] tx_q, tx_d;
    logic [13:0]  ctrl_q, ctrl_d;
    logic [15:0]  div_q, div_d;
    logic [7:0]   ss_q, ss_d;
    logic [31:0]  dat_q, dat_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         int_q, int_d;

    logic         req;
    logic         wr_en;
    logic [2:0]   word;
    logic [31:0]  lane_mask;
    logic [31:0]  rd_data;
    logic [31:0]  old_word;
    logic [31:0]  merged;
    logic         unused_adr_bits;

    assign unused_adr_bits = ^wb.adr_i[1:0];

    // Address decode and byte-lane merge; a request is only seen while no termination is showing,
    // which is what spaces back-to-back strobes to every second cycle.
    always_comb begin
        word      = wb.adr_i[4:2];
        req       = wb.cyc_i & wb.stb_i & ~ack_q & ~err_q;
        wr_en     = req & wb.we_i & (word != 3'd7) & ~ctrl_q[GO_BIT];
        lane_mask = {{8{wb.sel_i[3]}}, {8{wb.sel_i[2]}}, {8{wb.sel_i[1]}}, {8{wb.sel_i[0]}}};
        rd_data   = '0;
        old_word  = '0;
        case (word)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                rd_data  = rx_data_i[{word[1:0], 5'd0} +: 32];
                old_word = tx_q[{word[1:0], 5'd0} +: 32];
            end
            3'd4: begin
                rd_data  = {18'd0, ctrl_q};
                old_word = {18'd0, ctrl_q};
            end
            3'd5: begin
                rd_data  = {16'd0, div_q};
                old_word = {16'd0, div_q};
            end
            3'd6: begin
                rd_data  = {24'd0, ss_q};
                old_word = {24'd0, ss_q};
            end
            default: begin
                rd_data  = '0;
                old_word = '0;
            end
        endcase
        merged = (old_word & ~lane_mask) | (wb.dat_i & lane_mask);
    end

    always_comb begin
        tx_d   = tx_q;
        ctrl_d = ctrl_q;
        div_d  = div_q;
        ss_d   = ss_q;
        dat_d  = dat_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        int_d  = int_q;

        if (req) begin
            if (word == 3'd7) begin
                err_d = 1'b1;
                dat_d = '0;
            end else begin
                ack_d = 1'b1;
                dat_d = rd_data;
            end
        end

        if (wr_en) begin
            case (word)
                3'd0, 3'd1, 3'd2, 3'd3: tx_d[{word[1:0], 5'd0} +: 32] = merged;
                3'd4:                   ctrl_d = merged[13:0] & CTRL_WMASK;
                3'd5:                   div_d  = merged[15:0];
                3'd6:                   ss_d   = merged[7:0];
                default:                ;
            endcase
        end

        // Completion beats a simultaneous GO write; an interrupt set beats the ack-driven clear.
        if (xfer_done_i) begin
            ctrl_d[GO_BIT] = 1'b0;
        end
        if (ack_q) begin
            int_d = 1'b0;
        end
        if (xfer_done_i && ctrl_q[IE_BIT]) begin
            int_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_q   <= '0;
            ctrl_q <= '0;
            div_q  <= 16'hFFFF;
            ss_q   <= '0;
            dat_q  <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            ctrl_q <= ctrl_d;
            div_q  <= div_d;
            ss_q   <= ss_d;
            dat_q  <= dat_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            int_q  <= int_d;
        end
    end

    assign wb.dat_o  = dat_q;
    assign wb.ack_o  = ack_q;
    assign wb.err_o  = err_q;
    assign tx_data_o = tx_q;
    assign ctrl_o    = ctrl_q;
    assign divider_o = div_q;
    assign ss_o      = ss_q;
    assign int_o     = int_q;
endmodule
